// File: rtl/gfx256_fragment_if.sv
// Bus bundles around the fragment stage: clip-side pixel handshake, texel line
// reader and blender-side pixel handshake.

interface gfx256_clip_if #(parameter int point_width = 16);
  logic                   texture_enable_i;
  logic                   colorkey_enable_i;
  logic [1:0]             color_depth_i;
  logic [26:0]            tex_base_i;
  logic [point_width-1:0] tex_size_x_i;
  logic [31:0]            colorkey_i;
  logic [7:0]             global_alpha_i;
  logic [point_width-1:0] pixel_x_i;
  logic [point_width-1:0] pixel_y_i;
  logic [point_width-1:0] pixel_z_i;
  logic [point_width-1:0] u_i;
  logic [point_width-1:0] v_i;
  logic [7:0]             a_i;
  logic [31:0]            color_i;
  logic                   write_i;
  logic                   ack_o;

  modport master (
    output texture_enable_i, colorkey_enable_i, color_depth_i, tex_base_i,
           tex_size_x_i, colorkey_i, global_alpha_i, pixel_x_i, pixel_y_i,
           pixel_z_i, u_i, v_i, a_i, color_i, write_i,
    input  ack_o
  );

  modport slave (
    input  texture_enable_i, colorkey_enable_i, color_depth_i, tex_base_i,
           tex_size_x_i, colorkey_i, global_alpha_i, pixel_x_i, pixel_y_i,
           pixel_z_i, u_i, v_i, a_i, color_i, write_i,
    output ack_o
  );
endinterface

interface gfx256_tex_if;
  logic         tex_request_o;
  logic [26:0]  tex_addr_o;
  logic [255:0] tex_data_i;
  logic         tex_ack_i;
  logic         wbm_busy_i;

  modport master (
    output tex_request_o, tex_addr_o,
    input  tex_data_i, tex_ack_i, wbm_busy_i
  );

  modport slave (
    input  tex_request_o, tex_addr_o,
    output tex_data_i, tex_ack_i, wbm_busy_i
  );
endinterface

interface gfx256_blend_if #(parameter int point_width = 16);
  logic [point_width-1:0] pixel_x_o;
  logic [point_width-1:0] pixel_y_o;
  logic [point_width-1:0] pixel_z_o;
  logic [7:0]             a_o;
  logic [31:0]            color_o;
  logic                   write_o;
  logic                   ack_i;

  modport master (
    output pixel_x_o, pixel_y_o, pixel_z_o, a_o, color_o, write_o,
    input  ack_i
  );

  modport slave (
    input  pixel_x_o, pixel_y_o, pixel_z_o, a_o, color_o, write_o,
    output ack_i
  );
endinterface

// File: rtl/gfx256_fragment.sv
// Fragment stage: optional texel fetch from a 256-bit line, colorkey discard,
// global-alpha modulation, then one-pixel handoff to the blender.

module gfx256_fragment #(
  parameter int point_width = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  gfx256_clip_if.slave    clip,
  gfx256_tex_if.master    tex,
  gfx256_blend_if.master  blend
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_REQ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                   r_ck_en;
  logic [1:0]             r_depth;
  logic [26:0]            r_base;
  logic [point_width-1:0] r_size_x;
  logic [31:0]            r_ck;
  logic [7:0]             r_ga;
  logic [point_width-1:0] r_x;
  logic [point_width-1:0] r_y;
  logic [point_width-1:0] r_z;
  logic [point_width-1:0] r_u;
  logic [point_width-1:0] r_v;
  logic [7:0]             r_a;

  logic [4:0]  r_lane;
  logic [26:0] r_tex_addr;
  logic        r_tex_req;
  logic        r_write;
  logic        r_ack;
  logic [31:0] r_color_out;
  logic [7:0]  r_a_out;

  logic [31:0] w_linear;
  logic [31:0] w_offset;
  logic [7:0]  w_bytes  [32];
  logic [15:0] w_halves [16];
  logic [31:0] w_words  [8];
  logic [31:0] w_texel;
  logic [31:0] w_key_mask;
  logic        w_key_hit;
  logic [7:0]  w_a_src;
  logic [7:0]  w_ga_src;
  logic [15:0] w_alpha_prod;
  logic [7:0]  w_alpha;

  // Byte address of the texel inside texture memory, 32-bit wrap.
  assign w_linear = 32'(r_v) * 32'(r_size_x) + 32'(r_u);
  always_comb begin
    w_offset = w_linear;
    case (r_depth)
      2'b00:   w_offset = w_linear;
      2'b01:   w_offset = w_linear << 1;
      default: w_offset = w_linear << 2;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bytes
      assign w_bytes[gi] = tex.tex_data_i[8*gi +: 8];
    end
    for (gi = 0; gi < 16; gi++) begin : g_halves
      assign w_halves[gi] = tex.tex_data_i[16*gi +: 16];
    end
    for (gi = 0; gi < 8; gi++) begin : g_words
      assign w_words[gi] = tex.tex_data_i[32*gi +: 32];
    end
  endgenerate

  always_comb begin
    w_texel    = w_words[r_lane[4:2]];
    w_key_mask = 32'hFFFF_FFFF;
    case (r_depth)
      2'b00: begin
        w_texel    = {24'h0, w_bytes[r_lane]};
        w_key_mask = 32'h0000_00FF;
      end
      2'b01: begin
        w_texel    = {16'h0, w_halves[r_lane[4:1]]};
        w_key_mask = 32'h0000_FFFF;
      end
      default: begin
        w_texel    = w_words[r_lane[4:2]];
        w_key_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign w_key_hit = r_ck_en && (w_texel == (r_ck & w_key_mask));

  // Untextured pixels enter WRITE straight from IDLE, before capture completes.
  assign w_a_src      = (r_state == S_IDLE) ? clip.a_i : r_a;
  assign w_ga_src     = (r_state == S_IDLE) ? clip.global_alpha_i : r_ga;
  assign w_alpha_prod = w_a_src * w_ga_src;
  assign w_alpha      = (w_ga_src == 8'hFF) ? w_a_src : 8'(w_alpha_prod >> 8);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (clip.write_i) w_state_next = clip.texture_enable_i ? S_ADDR : S_WRITE;
      S_ADDR:  w_state_next = S_REQ;
      S_REQ:   if (tex.tex_ack_i) w_state_next = w_key_hit ? S_DONE : S_WRITE;
      S_WRITE: if (blend.ack_i) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ck_en     <= 1'b0;
      r_depth     <= 2'b00;
      r_base      <= '0;
      r_size_x    <= '0;
      r_ck        <= '0;
      r_ga        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_u         <= '0;
      r_v         <= '0;
      r_a         <= '0;
      r_lane      <= '0;
      r_tex_addr  <= '0;
      r_tex_req   <= 1'b0;
      r_write     <= 1'b0;
      r_ack       <= 1'b0;
      r_color_out <= '0;
      r_a_out     <= '0;
    end else begin
      r_write <= 1'b0;
      r_ack   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clip.write_i) begin
            r_ck_en  <= clip.colorkey_enable_i;
            r_depth  <= clip.color_depth_i;
            r_base   <= clip.tex_base_i;
            r_size_x <= clip.tex_size_x_i;
            r_ck     <= clip.colorkey_i;
            r_ga     <= clip.global_alpha_i;
            r_x      <= clip.pixel_x_i;
            r_y      <= clip.pixel_y_i;
            r_z      <= clip.pixel_z_i;
            r_u      <= clip.u_i;
            r_v      <= clip.v_i;
            r_a      <= clip.a_i;
            if (!clip.texture_enable_i) begin
              r_write     <= 1'b1;
              r_color_out <= clip.color_i;
              r_a_out     <= w_alpha;
            end
          end
        end
        S_ADDR: begin
          r_tex_addr <= r_base + w_offset[31:5];
          r_lane     <= w_offset[4:0];
        end
        S_REQ: begin
          if (tex.tex_ack_i) begin
            r_tex_req <= 1'b0;
            if (w_key_hit) begin
              r_ack <= 1'b1;
            end else begin
              r_write     <= 1'b1;
              r_color_out <= w_texel;
              r_a_out     <= w_alpha;
            end
          end else begin
            r_tex_req <= r_tex_req | ~tex.wbm_busy_i;
          end
        end
        S_WRITE: if (blend.ack_i) r_ack <= 1'b1;
        default: ;
      endcase
    end
  end

  assign clip.ack_o        = r_ack;
  assign tex.tex_request_o = r_tex_req;
  assign tex.tex_addr_o    = r_tex_addr;
  assign blend.pixel_x_o   = r_x;
  assign blend.pixel_y_o   = r_y;
  assign blend.pixel_z_o   = r_z;
  assign blend.a_o         = r_a_out;
  assign blend.color_o     = r_color_out;
  assign blend.write_o     = r_write;

endmodule

// File: tb/tb_gfx256_fragment.sv
// Directed bench for gfx256_fragment: per-pixel reference model from byte
// arithmetic plus a per-cycle compare process on the blender-side outputs.

module tb_gfx256_fragment;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gfx256_clip_if  #(.point_width(PW)) clip ();
  gfx256_tex_if                       tex ();
  gfx256_blend_if #(.point_width(PW)) blend ();

  gfx256_fragment #(.point_width(PW)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .clip  (clip.slave),
    .tex   (tex.master),
    .blend (blend.master)
  );

  int checks = 0;
  int errors = 0;
  int n_writes = 0;

  logic        exp_tex = 1'b0;
  logic [31:0] exp_color = '0;
  logic [7:0]  exp_a = '0;
  logic [15:0] exp_x = '0;
  logic [15:0] exp_y = '0;
  logic [15:0] exp_z = '0;

  logic [7:0] line_b [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_default();
    for (int k = 0; k < 32; k++) line_b[k] = 8'(k * 3 + 1);
  endtask

  function automatic logic [255:0] pack_line();
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 32; k++) l[8*k +: 8] = line_b[k];
    return l;
  endfunction

  // Every blender handoff is compared against the model's current pixel.
  always @(negedge clk) begin
    if (blend.write_o) begin
      n_writes++;
      chk("color_o", blend.color_o, exp_color);
      chk("a_o", blend.a_o, exp_a);
      chk("pixel_x_o", blend.pixel_x_o, exp_x);
      chk("pixel_y_o", blend.pixel_y_o, exp_y);
      chk("pixel_z_o", blend.pixel_z_o, exp_z);
    end
    if (tex.tex_request_o) chk("req_only_textured", exp_tex, 1);
  end

  task automatic run_pixel(
    input bit ten, input bit cken, input logic [1:0] depth,
    input logic [26:0] base, input logic [15:0] sx, input logic [15:0] u,
    input logic [15:0] v, input logic [31:0] ck, input logic [31:0] color,
    input logic [7:0] a, input logic [7:0] ga, input int busy_n, input int ack_dly,
    input logic [26:0] lit_addr, input logic [31:0] lit_color,
    input logic [7:0] lit_a, input bit lit_disc);
    longint      off;
    logic [26:0] m_addr;
    int          nbytes, start, w0, k;
    logic [31:0] texel, keymask;
    bit          disc;

    nbytes  = (depth == 2'd0) ? 1 : (depth == 2'd1) ? 2 : 4;
    off     = ((longint'(v) * longint'(sx) + longint'(u)) * nbytes) & 64'hFFFF_FFFF;
    m_addr  = 27'((longint'(base) + (off >> 5)) % (64'd1 << 27));
    start   = int'(off % 32);
    texel   = '0;
    for (int i = 0; i < nbytes; i++) texel |= 32'(line_b[start + i]) << (8 * i);
    keymask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    disc    = ten && cken && (texel == (ck & keymask));

    exp_tex   = ten;
    exp_color = ten ? texel : color;
    exp_a     = (ga == 8'hFF) ? a : 8'((int'(a) * int'(ga)) / 256);
    exp_x     = u + 16'd100;
    exp_y     = v + 16'd200;
    exp_z     = u + 16'h3000;

    chk("model_color", exp_color, lit_color);
    chk("model_alpha", exp_a, lit_a);
    chk("model_discard", disc, lit_disc);
    if (ten) chk("model_addr", m_addr, lit_addr);

    clip.texture_enable_i  = ten;
    clip.colorkey_enable_i = cken;
    clip.color_depth_i     = depth;
    clip.tex_base_i        = base;
    clip.tex_size_x_i      = sx;
    clip.colorkey_i        = ck;
    clip.global_alpha_i    = ga;
    clip.pixel_x_i         = exp_x;
    clip.pixel_y_i         = exp_y;
    clip.pixel_z_i         = exp_z;
    clip.u_i               = u;
    clip.v_i               = v;
    clip.a_i               = a;
    clip.color_i           = color;
    tex.wbm_busy_i         = (busy_n > 0);
    w0 = n_writes;

    clip.write_i = 1'b1;
    step();
    clip.write_i = 1'b0;

    if (ten) begin
      step();
      chk("tex_addr_o", tex.tex_addr_o, m_addr);
      chk("req_at_req_entry", tex.tex_request_o, 0);
      for (int b = 0; b < busy_n; b++) begin
        step();
        chk("req_while_busy", tex.tex_request_o, 0);
      end
      tex.wbm_busy_i = 1'b0;
      k = 0;
      while (!tex.tex_request_o && k < 20) begin
        step();
        k++;
      end
      chk("req_rise", tex.tex_request_o, 1);
      tex.wbm_busy_i = 1'b1;
      for (int h = 0; h < 2; h++) begin
        step();
        chk("req_hold", tex.tex_request_o, 1);
      end
      tex.wbm_busy_i = 1'b0;
      tex.tex_data_i = pack_line();
      tex.tex_ack_i  = 1'b1;
      step();
      tex.tex_ack_i  = 1'b0;
      chk("req_drop", tex.tex_request_o, 0);
    end

    if (disc) begin
      chk("ack_o_discard", clip.ack_o, 1);
      chk("write_o_discard", blend.write_o, 0);
      step();
      chk("ack_o_single", clip.ack_o, 0);
      chk("no_write_on_discard", n_writes - w0, 0);
    end else begin
      chk("write_o_latency", blend.write_o, 1);
      if (ack_dly == 0) begin
        blend.ack_i = 1'b1;
        step();
        blend.ack_i = 1'b0;
      end else begin
        step();
        chk("write_o_one_cycle", blend.write_o, 0);
        for (int d = 1; d < ack_dly; d++) step();
        chk("ack_o_before_ack_i", clip.ack_o, 0);
        blend.ack_i = 1'b1;
        step();
        blend.ack_i = 1'b0;
      end
      chk("ack_o_pulse", clip.ack_o, 1);
      step();
      chk("ack_o_single", clip.ack_o, 0);
      chk("one_write", n_writes - w0, 1);
    end
    $display("TXN tex=%0d depth=%0d u=%0d v=%0d addr=%07h color=%08h a=%02h discard=%0d",
             ten, depth, u, v, m_addr, exp_color, exp_a, disc);
  endtask

  initial begin
    int k, w0;
    clip.texture_enable_i = 0; clip.colorkey_enable_i = 0; clip.color_depth_i = 0;
    clip.tex_base_i = 0; clip.tex_size_x_i = 0; clip.colorkey_i = 0;
    clip.global_alpha_i = 0; clip.pixel_x_i = 0; clip.pixel_y_i = 0;
    clip.pixel_z_i = 0; clip.u_i = 0; clip.v_i = 0; clip.a_i = 0;
    clip.color_i = 0; clip.write_i = 0;
    tex.tex_data_i = '0; tex.tex_ack_i = 0; tex.wbm_busy_i = 0;
    blend.ack_i = 0;
    fill_default();

    repeat (3) step();
    chk("rst_write_o", blend.write_o, 0);
    chk("rst_ack_o", clip.ack_o, 0);
    chk("rst_req", tex.tex_request_o, 0);
    chk("rst_addr", tex.tex_addr_o, 0);
    chk("rst_color", blend.color_o, 0);
    chk("rst_a", blend.a_o, 0);
    rst_n = 1'b1;
    step();

    // Untextured pass-through.
    run_pixel(0, 0, 2'd0, 27'h0, 16'd0, 16'd0, 16'd0, 32'h0, 32'h11223344,
              8'h80, 8'hFF, 0, 2, 27'h0, 32'h11223344, 8'h80, 0);

    // 32bpp, word 3 of line 0x110.
    fill_default();
    line_b[12] = 8'hBE; line_b[13] = 8'hBA; line_b[14] = 8'hFE; line_b[15] = 8'hCA;
    run_pixel(1, 0, 2'd2, 27'h100, 16'd64, 16'd3, 16'd2, 32'h0, 32'hDEADBEEF,
              8'h40, 8'hC0, 0, 1, 27'h110, 32'hCAFEBABE, 8'h30, 0);

    // 8bpp byte 5.
    fill_default();
    line_b[5] = 8'hA5;
    run_pixel(1, 0, 2'd0, 27'h200, 16'd64, 16'd5, 16'd0, 32'h0, 32'h0,
              8'h7F, 8'hFF, 0, 1, 27'h200, 32'h000000A5, 8'h7F, 0);

    // 16bpp u=17: next line, halfword 1; blender acks in the write cycle.
    fill_default();
    line_b[2] = 8'h3C; line_b[3] = 8'h5A;
    run_pixel(1, 0, 2'd1, 27'h200, 16'd64, 16'd17, 16'd0, 32'h0, 32'h0,
              8'h10, 8'hFF, 0, 0, 27'h201, 32'h00005A3C, 8'h10, 0);

    // Colorkey hits at 16bpp and 8bpp; 32bpp near-miss still written.
    fill_default();
    line_b[0] = 8'h1F; line_b[1] = 8'hF8;
    run_pixel(1, 1, 2'd1, 27'h300, 16'd64, 16'd0, 16'd0, 32'h1234F81F, 32'h0,
              8'h20, 8'hFF, 0, 1, 27'h300, 32'h0000F81F, 8'h20, 1);
    fill_default();
    line_b[1] = 8'h11;
    run_pixel(1, 1, 2'd0, 27'h300, 16'd64, 16'd1, 16'd0, 32'hFFFFFF11, 32'h0,
              8'h20, 8'hFF, 0, 1, 27'h300, 32'h00000011, 8'h20, 1);
    fill_default();
    line_b[0] = 8'h1F; line_b[1] = 8'hF8; line_b[2] = 8'h00; line_b[3] = 8'h00;
    run_pixel(1, 1, 2'd2, 27'h300, 16'd64, 16'd0, 16'd0, 32'h1234F81F, 32'h0,
              8'h20, 8'hFF, 0, 1, 27'h300, 32'h0000F81F, 8'h20, 0);

    // Reader busy for 5 cycles; line address wraps to 0.
    fill_default();
    line_b[0] = 8'h04; line_b[1] = 8'h03; line_b[2] = 8'h02; line_b[3] = 8'h01;
    run_pixel(1, 0, 2'd2, 27'h7FFFFFF, 16'd8, 16'd0, 16'd1, 32'h0, 32'h0,
              8'hFF, 8'hFF, 5, 1, 27'h0, 32'h01020304, 8'hFF, 0);

    // Global alpha modulation.
    run_pixel(0, 0, 2'd0, 27'h0, 16'd0, 16'd0, 16'd0, 32'h0, 32'h55AA55AA,
              8'h80, 8'h80, 0, 0, 27'h0, 32'h55AA55AA, 8'h40, 0);

    // Reset while the texel request is outstanding.
    fill_default();
    exp_tex = 1'b1;
    clip.texture_enable_i = 1; clip.colorkey_enable_i = 0; clip.color_depth_i = 2'd2;
    clip.tex_base_i = 27'h40; clip.tex_size_x_i = 16'd4; clip.u_i = 16'd1;
    clip.v_i = 16'd1; clip.pixel_x_i = 16'd77; clip.a_i = 8'h80;
    clip.global_alpha_i = 8'h80;
    w0 = n_writes;
    clip.write_i = 1'b1;
    step();
    clip.write_i = 1'b0;
    step();
    k = 0;
    while (!tex.tex_request_o && k < 20) begin
      step();
      k++;
    end
    chk("rst_test_req_up", tex.tex_request_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", tex.tex_request_o, 0);
    chk("async_rst_addr", tex.tex_addr_o, 0);
    chk("async_rst_color", blend.color_o, 0);
    chk("async_rst_a", blend.a_o, 0);
    chk("async_rst_x", blend.pixel_x_o, 0);
    chk("async_rst_write", blend.write_o, 0);
    chk("async_rst_ack", clip.ack_o, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("no_ack_after_rst", clip.ack_o, 0);
      chk("no_req_after_rst", tex.tex_request_o, 0);
    end
    chk("no_write_after_rst", n_writes - w0, 0);
    $display("TXN reset-abort during fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gfx256_fragment.md
Name: gfx256_fragment

Overview:
- Fragment stage that sits directly downstream of the clip/z-cull stage and upstream of the blender.
- Accepts one surviving pixel at a time and, when texturing is enabled, fetches the texel through the wishbone-master reader as a 256-bit line.
- Extracts the texel, applies colorkey discard and global-alpha modulation, then forwards the pixel to the blender.

Parameters:
point_width, 16, coordinate width for x/y/z/u/v

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
texture_enable_i  in  1  use texel instead of input color
colorkey_enable_i  in  1  discard texels equal to colorkey_i
color_depth_i  in  2  00=8bpp, 01=16bpp, 10/11=32bpp
tex_base_i  in  27  texture base address [31:5]
tex_size_x_i  in  point_width  texture width in pixels
colorkey_i  in  32  colorkey (compared on low depth bits)
global_alpha_i  in  8  global alpha
pixel_x_i, pixel_y_i, pixel_z_i  in  point_width each  from clip
u_i, v_i  in  point_width each  texture coordinates from clip
a_i  in  8  alpha from clip
color_i  in  32  flat/interpolated color from clip
write_i  in  1  one-cycle pixel-valid pulse from clip
ack_o  out  1  one-cycle completion pulse to clip
tex_request_o  out  1  texel read request (level)
tex_addr_o  out  27  line address [31:5]
tex_data_i  in  256  read line
tex_ack_i  in  1  read complete, data valid this cycle
wbm_busy_i  in  1  reader busy
pixel_x_o, pixel_y_o, pixel_z_o  out  point_width each  to blender
a_o  out  8  modulated alpha
color_o  out  32  final color
write_o  out  1  one-cycle pixel-valid pulse to blender
ack_i  in  1  blender completion

Behaviour:
- Reset (rst_i low, async): every output is 0; state is IDLE.
- Upstream inputs are stable from the write_i pulse until ack_o. All inputs are captured in registers on the write_i cycle.
- States:
  - IDLE: on write_i, capture inputs. Go to ADDR if texture_enable_i, else to WRITE.
  - ADDR: one cycle.
    - Registers the byte offset (v*tex_size_x + u) << shift, where shift is 0/1/2 for 8/16/32bpp. The arithmetic is 32-bit unsigned, and the product is truncated to 32 bits.
    - tex_addr_o = tex_base_i + offset[31:5], wrapping mod 2^27.
    - lane = offset[4:0].
    - Next state is REQ.
  - REQ: tex_request_o <= tex_request_o | ~wbm_busy_i.
    - On tex_ack_i, drop the request and extract the texel, little-endian byte lane k = tex_data_i[8k+7:8k]:
      - 8bpp: the byte at lane, zero-extended.
      - 16bpp: the halfword at lane[4:1].
      - 32bpp: the word at lane[4:2].
    - If colorkey_enable_i and the texel equals colorkey_i masked to depth width: go to DONE with discard. Otherwise latch the texel into color and go to WRITE.
  - WRITE: write_o pulses high for exactly one cycle, then the block waits for ack_i.
    - ack_i in the same cycle as the write_o pulse is legal.
    - On ack_i, go to DONE.
  - DONE: ack_o pulses high one cycle. Next state is IDLE.
- Alpha: a_o = a_i when global_alpha_i = 255, else (a_i*global_alpha_i)>>8. a_o is registered with the other outputs on entry to WRITE.
- pixel_x/y/z outputs are the captured values.
- Latency from write_i to write_o:
  - Untextured: 1 cycle.
  - Textured: 3 cycles plus reader latency.
- write_i outside IDLE is ignored; the protocol forbids it.
- tex_request_o never asserts while texture_enable_i was low at capture.
- Reset mid-fetch aborts immediately: request drops, no ack_o is issued, state returns to IDLE.

Test Plan:
1. Untextured: color_i=0x11223344, a_i=0x80, global_alpha=0xFF, write_i pulse -> write_o 1 cycle later with color_o=0x11223344, a_o=0x80; ack_i -> ack_o next cycle.
2. 32bpp texel: tex_base=0x100, tex_size_x=64, u=3, v=2, offset=0x20C -> tex_addr_o=0x110, lane 0x0C; word 3 of tex_data_i=0xCAFEBABE -> color_o=0xCAFEBABE.
3. 8bpp and 16bpp: u=5, v=0, 8bpp -> byte 5 zero-extended; 16bpp, u=17 -> offset 34, line +1, halfword 1.
4. Colorkey: 16bpp texel 0xF81F, colorkey_i=0x1234F81F, enable=1 -> no write_o, single ack_o pulse, tex_request_o low after tex_ack_i.
5. Busy arbitration: wbm_busy_i high 5 cycles in REQ -> tex_request_o stays low, then rises and holds until tex_ack_i.
6. Alpha: a_i=0x80, global_alpha=0x80 -> a_o=0x40. Assert rst_i low during REQ -> all outputs 0 asynchronously, no ack_o after release.
